// File: rtl/mux_port_arbiter.sv
// Round-robin arbiter granting one shared datapath resource to one of NREQ requesters.
// Optional hold watchdog enabled by defining ARB_WATCHDOG_EN.
module mux_port_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned SEL_W    = 2,
   parameter int unsigned MAX_HOLD = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req_i,
   input  logic             done_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [SEL_W-1:0] sel_o,
   output logic             busy_o,
   output logic             timeout_o
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
      $error("mux_port_arbiter: NREQ must be in 2..8");
   end
   if (SEL_W != $clog2(NREQ)) begin : g_chk_selw
      $error("mux_port_arbiter: SEL_W must equal $clog2(NREQ)");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_chk_hold
      $error("mux_port_arbiter: MAX_HOLD must be in 1..65535");
   end

   state_e           state_q;
   logic [NREQ-1:0]  gnt_q;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] ptr_q;
   logic             busy_q;

   logic [SEL_W-1:0] cand_c;
   logic [SEL_W-1:0] win_idx_c;
   logic             win_vld_c;
   logic             expire_c;
   logic [SEL_W-1:0] ptr_d;

   // Rotating-priority search: first asserted request at or after ptr, modulo NREQ.
   always_comb begin
      cand_c    = '0;
      win_idx_c = '0;
      win_vld_c = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand_c = SEL_W'((32'(ptr_q) + i) % NREQ);
         if (!win_vld_c && req_i[cand_c]) begin
            win_vld_c = 1'b1;
            win_idx_c = cand_c;
         end
      end
   end

   assign ptr_d = (sel_q == SEL_W'(NREQ - 1)) ? '0 : sel_q + SEL_W'(1);

`ifdef ARB_WATCHDOG_EN
   localparam int unsigned CNT_W = (MAX_HOLD > 255) ? 16 : 8;

   logic [CNT_W-1:0] wdog_q;
   logic [CNT_W-1:0] wdog_d;
   logic             timeout_q;

   // wdog_d is the number of BUSY cycles completed at this edge.
   assign wdog_d   = wdog_q + CNT_W'(1);
   assign expire_c = (state_q == ST_BUSY) && !done_i && (wdog_d == CNT_W'(MAX_HOLD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= (state_q == ST_BUSY) ? wdog_d : '0;
         timeout_q <= expire_c;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign expire_c  = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // Grant FSM: latch the winner from IDLE, hold it in BUSY until done or watchdog release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_vld_c) begin
                  state_q <= ST_BUSY;
                  gnt_q   <= NREQ'(1) << win_idx_c;
                  sel_q   <= win_idx_c;
                  busy_q  <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (done_i || expire_c) begin
                  state_q <= ST_IDLE;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  ptr_q   <= ptr_d;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o  = gnt_q;
   assign sel_o  = sel_q;
   assign busy_o = busy_q;

endmodule
